// File: rtl/gpio_mmio_port.sv
// Memory-mapped GPIO output port for the core data bus.
// Direct/set/clear/toggle writes, timed auto-clearing pulse, registered read-back.
module gpio_mmio_port #(
   parameter int unsigned            BIT_WIDTH    = 32,
   parameter int unsigned            GPIO_WIDTH   = 9,
   parameter logic [BIT_WIDTH-1:0]   BASE_ADDR    = 'h1001_0000,
   parameter int unsigned            PULSE_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIT_WIDTH-1:0]  addr,
   input  logic [BIT_WIDTH-1:0]  wdata,
   input  logic                  we,
   input  logic                  re,
   output logic [BIT_WIDTH-1:0]  rd_data,
   output logic                  rd_valid,
   output logic                  sel,
   output logic [GPIO_WIDTH-1:0] GPIO_PORT_OUT
);

   localparam logic [2:0] OFF_DATA   = 3'd0;
   localparam logic [2:0] OFF_SET    = 3'd1;
   localparam logic [2:0] OFF_CLR    = 3'd2;
   localparam logic [2:0] OFF_TGL    = 3'd3;
   localparam logic [2:0] OFF_PULSE  = 3'd4;
   localparam logic [2:0] OFF_STATUS = 3'd5;

   localparam logic [15:0] CNT_LOAD = 16'(PULSE_CYCLES - 1);

   typedef enum logic {
      S_IDLE,
      S_PULSE
   } state_e;

   state_e                state_q, state_d;
   logic [GPIO_WIDTH-1:0] port_q, port_d;
   logic [GPIO_WIDTH-1:0] mask_q, mask_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [BIT_WIDTH-1:0]  rdat_q, rdat_d;
   logic                  rvld_q, rvld_d;

   logic [2:0]            off;
   logic [GPIO_WIDTH-1:0] w;
   logic [GPIO_WIDTH-1:0] base;
   logic                  wr_en;
   logic                  rd_en;
   logic                  busy;
   logic                  expire;
   logic                  pulse_wr;
   logic                  unused_ok;

   assign sel      = (addr[BIT_WIDTH-1:5] == BASE_ADDR[BIT_WIDTH-1:5]);
   assign off      = addr[4:2];
   assign w        = wdata[GPIO_WIDTH-1:0];
   assign wr_en    = we & sel;
   assign rd_en    = re & sel & ~we;
   assign busy     = (state_q == S_PULSE);
   assign expire   = busy && (cnt_q == 16'd0);
   assign pulse_wr = wr_en && (off == OFF_PULSE) && (w != '0);

   assign unused_ok = ^{addr[1:0], wdata[BIT_WIDTH-1:GPIO_WIDTH]};

   // Expiry clear lands first so a same-cycle write acts on the cleared port
   assign base = expire ? (port_q & ~mask_q) : port_q;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
         end
         S_PULSE: begin
            if (cnt_q == 16'd0) begin
               state_d = S_IDLE;
               mask_d  = '0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (pulse_wr) begin
         state_d = S_PULSE;
         mask_d  = w;
         cnt_d   = CNT_LOAD;
      end
   end

   always_comb begin
      port_d = base;
      if (wr_en) begin
         unique case (off)
            OFF_DATA:  port_d = w;
            OFF_SET:   port_d = base | w;
            OFF_CLR:   port_d = base & ~w;
            OFF_TGL:   port_d = base ^ w;
            OFF_PULSE: port_d = base | w;
            default:   port_d = base;
         endcase
      end
   end

   always_comb begin
      rvld_d = rd_en;
      rdat_d = rdat_q;
      if (rd_en) begin
         rdat_d = '0;
         unique case (off)
            OFF_DATA: begin
               rdat_d[GPIO_WIDTH-1:0] = port_q;
            end
            OFF_STATUS: begin
               rdat_d[0]     = busy;
               rdat_d[31:16] = cnt_q;
            end
            default: begin
               rdat_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         port_q  <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         rdat_q  <= '0;
         rvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         rdat_q  <= rdat_d;
         rvld_q  <= rvld_d;
      end
   end

   assign GPIO_PORT_OUT = port_q;
   assign rd_data       = rdat_q;
   assign rd_valid      = rvld_q;

endmodule

// File: tb/tb_gpio_mmio_port.sv
// Directed bench for gpio_mmio_port.
// Drives on negedge, checks on negedge, expected values hand-computed.
module tb_gpio_mmio_port;

   localparam logic [31:0] A_DATA = 32'h1001_0000;
   localparam logic [31:0] A_SET  = 32'h1001_0004;
   localparam logic [31:0] A_CLR  = 32'h1001_0008;
   localparam logic [31:0] A_TGL  = 32'h1001_000C;
   localparam logic [31:0] A_PLS  = 32'h1001_0010;
   localparam logic [31:0] A_STS  = 32'h1001_0014;
   localparam logic [31:0] A_OFF6 = 32'h1001_0018;
   localparam logic [31:0] A_OUT  = 32'h1001_0040;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic        re;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        sel;
   logic [8:0]  gpio;

   int n_vec = 0;
   int n_bad = 0;

   gpio_mmio_port dut (
      .clk           (clk),
      .rst           (rst),
      .addr          (addr),
      .wdata         (wdata),
      .we            (we),
      .re            (re),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .sel           (sel),
      .GPIO_PORT_OUT (gpio)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(negedge clk);
      we    = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      @(negedge clk);
      addr = a;
      re   = 1'b1;
      @(negedge clk);
      re   = 1'b0;
   endtask

   initial begin
      rst   = 1'b0;
      addr  = '0;
      wdata = '0;
      we    = 1'b0;
      re    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_port",  {23'd0, gpio}, 32'h000);
      chk("rst_rvld",  {31'd0, rd_valid}, 32'd0);
      chk("rst_rdat",  rd_data, 32'd0);
      chk("sel_out",   {31'd0, sel}, 32'd0);
      addr = A_STS;
      #1;
      chk("sel_in",    {31'd0, sel}, 32'd1);

      wr(A_DATA, 32'h0000_01A5);
      chk("data",      {23'd0, gpio}, 32'h1A5);
      wr(A_SET, 32'h0000_0002);
      chk("set",       {23'd0, gpio}, 32'h1A7);
      wr(A_CLR, 32'h0000_0001);
      chk("clr",       {23'd0, gpio}, 32'h1A6);
      wr(A_TGL, 32'h0000_0100);
      chk("tgl",       {23'd0, gpio}, 32'h0A6);

      @(negedge clk);
      addr  = A_DATA;
      wdata = 32'h0000_0055;
      we    = 1'b1;
      re    = 1'b1;
      @(negedge clk);
      we = 1'b0;
      re = 1'b0;
      chk("we_re_port", {23'd0, gpio}, 32'h055);
      chk("we_re_rvld", {31'd0, rd_valid}, 32'd0);

      wr(A_DATA | 32'h3, 32'hFFFF_FEA0);
      chk("data_trunc", {23'd0, gpio}, 32'h0A0);
      wr(A_PLS, 32'h0000_000F);
      chk("pls_on",    {23'd0, gpio}, 32'h0AF);
      rd(A_STS);
      chk("sts_busy_v", {31'd0, rd_valid}, 32'd1);
      chk("sts_busy",  rd_data, 32'h03E6_0001);
      repeat (997) @(negedge clk);
      chk("pls_last",  {23'd0, gpio}, 32'h0AF);
      @(negedge clk);
      chk("pls_off",   {23'd0, gpio}, 32'h0A0);
      rd(A_STS);
      chk("sts_idle",  rd_data, 32'h0000_0000);

      wr(A_DATA, 32'h0000_0000);
      wr(A_PLS, 32'h0000_0003);
      chk("p1_on",     {23'd0, gpio}, 32'h003);
      repeat (498) @(negedge clk);
      wr(A_PLS, 32'h0000_000C);
      chk("p2_on",     {23'd0, gpio}, 32'h00F);
      repeat (999) @(negedge clk);
      chk("p2_last",   {23'd0, gpio}, 32'h00F);
      @(negedge clk);
      chk("p2_off",    {23'd0, gpio}, 32'h003);

      rd(A_OFF6);
      chk("off6_v",    {31'd0, rd_valid}, 32'd1);
      chk("off6_d",    rd_data, 32'd0);
      rd(A_DATA);
      chk("rdata_v",   {31'd0, rd_valid}, 32'd1);
      chk("rdata_d",   rd_data, 32'h003);
      @(negedge clk);
      chk("rvld_drop", {31'd0, rd_valid}, 32'd0);
      rd(A_OUT);
      chk("out_v",     {31'd0, rd_valid}, 32'd0);
      chk("out_hold",  rd_data, 32'h003);

      wr(A_DATA, 32'h0000_01FF);
      wr(A_PLS, 32'h0000_0010);
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_port", {23'd0, gpio}, 32'h000);
      chk("arst_rdat", rd_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      rd(A_STS);
      chk("arst_sts",  rd_data, 32'h0000_0000);

      wr(A_PLS, 32'h0000_0001);
      chk("e_on",      {23'd0, gpio}, 32'h001);
      repeat (998) @(negedge clk);
      wr(A_SET, 32'h0000_0001);
      chk("e_set",     {23'd0, gpio}, 32'h001);
      rd(A_STS);
      chk("e_sts",     rd_data, 32'h0000_0000);
      repeat (3) @(negedge clk);
      chk("e_hold",    {23'd0, gpio}, 32'h001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
